// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch sequencer: owns the program counter, drives the ROM
// address, and sequences IDLE -> RUN -> DONE under start/stall/halt/branch.
module inst_fetch_ctrl #(
    parameter int AW = 10,
    parameter int CW = 16
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_start,
    input  logic [AW-1:0] i_start_addr,
    input  logic          i_stall,
    input  logic          i_halt,
    input  logic          i_branch_en,
    input  logic          i_branch_rel,
    input  logic [AW-1:0] i_target,
    output logic [AW-1:0] o_inst_address,
    output logic          o_inst_valid,
    output logic          o_done,
    output logic          o_fault,
    output logic [CW-1:0] o_cycle_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [AW-1:0] r_pc;
    logic          r_fault;
    logic [CW-1:0] r_cycle_count;
    logic [AW-1:0] w_branch_pc;
    logic          w_pc_at_last;
    logic          w_count_sat;
    logic          w_inst_valid;
    logic          w_done;

    // Relative targets are two's-complement offsets; the AW-bit add wraps
    // modulo the ROM depth, which is the intended behaviour for branches.
    assign w_branch_pc  = i_branch_rel ? (r_pc + i_target) : i_target;
    assign w_pc_at_last = (r_pc == {AW{1'b1}});
    assign w_count_sat  = (r_cycle_count == {CW{1'b1}});

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decision: start wins, stall freezes, then halt or run-off-end
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_RUN: begin
                if (!i_start && !i_stall) begin
                    if (i_halt) begin
                        w_state_next = ST_DONE;
                    end else if (!i_branch_en && w_pc_at_last) begin
                        w_state_next = ST_DONE;
                    end
                end
            end
            default: begin
                if (i_start) begin
                    w_state_next = ST_RUN;
                end
            end
        endcase
    end

    // Status outputs are decoded purely from the state
    always_comb begin
        w_inst_valid = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            ST_RUN:  w_inst_valid = 1'b1;
            ST_DONE: w_done       = 1'b1;
            default: begin
                w_inst_valid = 1'b0;
                w_done       = 1'b0;
            end
        endcase
    end

    // PC, fault flag and saturating cycle counter
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pc          <= '0;
            r_fault       <= 1'b0;
            r_cycle_count <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (i_start) begin
                        r_pc          <= i_start_addr;
                        r_cycle_count <= '0;
                        r_fault       <= 1'b0;
                    end else begin
                        if (!w_count_sat) begin
                            r_cycle_count <= r_cycle_count + 1'b1;
                        end
                        if (!i_stall && !i_halt) begin
                            if (i_branch_en) begin
                                r_pc <= w_branch_pc;
                            end else if (!w_pc_at_last) begin
                                r_pc <= r_pc + 1'b1;
                            end else begin
                                // Sequential fetch off the end: hold PC, flag it
                                r_fault <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    if (i_start) begin
                        r_pc          <= i_start_addr;
                        r_cycle_count <= '0;
                        r_fault       <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign o_inst_address = r_pc;
    assign o_inst_valid   = w_inst_valid;
    assign o_done         = w_done;
    assign o_fault        = r_fault;
    assign o_cycle_count  = r_cycle_count;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Self-checking bench for inst_fetch_ctrl: directed scenarios followed by
// randomized traffic, all compared against a cycle-level behavioural model.
module tb_inst_fetch_ctrl;

    localparam int AW      = 10;
    localparam int CW      = 6;
    localparam int ROM_SZ  = 1 << AW;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] start_addr;
    logic          stall;
    logic          halt;
    logic          branch_en;
    logic          branch_rel;
    logic [AW-1:0] target;
    logic [AW-1:0] inst_address;
    logic          inst_valid;
    logic          done;
    logic          fault;
    logic [CW-1:0] cycle_count;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: mode 0 = idle, 1 = running, 2 = finished
    int m_mode;
    int m_pc;
    int m_cnt;
    int m_fault;

    inst_fetch_ctrl #(.AW(AW), .CW(CW)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_start        (start),
        .i_start_addr   (start_addr),
        .i_stall        (stall),
        .i_halt         (halt),
        .i_branch_en    (branch_en),
        .i_branch_rel   (branch_rel),
        .i_target       (target),
        .o_inst_address (inst_address),
        .o_inst_valid   (inst_valid),
        .o_done         (done),
        .o_fault        (fault),
        .o_cycle_count  (cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        check_eq("addr",  int'(inst_address), m_pc);
        check_eq("valid", int'(inst_valid),   (m_mode == 1) ? 1 : 0);
        check_eq("done",  int'(done),         (m_mode == 2) ? 1 : 0);
        check_eq("fault", int'(fault),        m_fault);
        check_eq("count", int'(cycle_count),  m_cnt);
    endtask

    task automatic model_reset();
        m_mode  = 0;
        m_pc    = 0;
        m_cnt   = 0;
        m_fault = 0;
    endtask

    // Advance the model by one clock edge using the rules of each mode
    task automatic model_edge(input bit st, input int sa, input bit sl, input bit hl,
                              input bit be, input bit br, input int tg);
        int off;
        if (m_mode != 1) begin
            if (st) begin
                m_mode = 1; m_pc = sa; m_cnt = 0; m_fault = 0;
            end
        end else if (st) begin
            m_pc = sa; m_cnt = 0; m_fault = 0;
        end else begin
            if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
            if (sl) begin
                // hold
            end else if (hl) begin
                m_mode = 2;
            end else if (be) begin
                if (br) begin
                    off  = (tg >= ROM_SZ / 2) ? tg - ROM_SZ : tg;
                    m_pc = (m_pc + off + ROM_SZ) % ROM_SZ;
                end else begin
                    m_pc = tg;
                end
            end else if (m_pc == ROM_SZ - 1) begin
                m_mode = 2; m_fault = 1;
            end else begin
                m_pc = m_pc + 1;
            end
        end
    endtask

    // One clock: drive on the falling edge, update model at the rising edge,
    // sample the DUT shortly after
    task automatic step(input bit st, input int sa, input bit sl, input bit hl,
                        input bit be, input bit br, input int tg);
        @(negedge clk);
        start      = st;
        start_addr = AW'(sa);
        stall      = sl;
        halt       = hl;
        branch_en  = be;
        branch_rel = br;
        target     = AW'(tg);
        @(posedge clk);
        model_edge(st, sa, sl, hl, be, br, tg);
        #1;
        check_outputs();
        $display("t=%0t st=%0b sa=%0d sl=%0b hl=%0b be=%0b br=%0b tg=%0d -> addr=%0d v=%0b d=%0b f=%0b cnt=%0d",
                 $time, st, sa, sl, hl, be, br, tg, inst_address, inst_valid, done, fault, cycle_count);
    endtask

    task automatic idle_step();
        step(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    endtask

    // Asynchronous reset dropped between edges must take effect at once
    task automatic async_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_eq("rst_addr",  int'(inst_address), 0);
        check_eq("rst_valid", int'(inst_valid),   0);
        check_eq("rst_done",  int'(done),         0);
        check_eq("rst_fault", int'(fault),        0);
        check_eq("rst_count", int'(cycle_count),  0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; start_addr = '0; stall = 1'b0; halt = 1'b0;
        branch_en = 1'b0; branch_rel = 1'b0; target = '0;
        model_reset();
        #2;
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        idle_step();

        // Run from 0, halt at address 5
        step(1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        for (int i = 0; i < 5; i++) idle_step();
        check_eq("pre_halt_addr", int'(inst_address), 5);
        step(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        check_eq("halt_done",  int'(done),        1);
        check_eq("halt_count", int'(cycle_count), 6);
        idle_step();

        // Stall three cycles at PC=12
        step(1'b1, 10, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        idle_step();
        idle_step();
        for (int i = 0; i < 3; i++) step(1'b0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 500);
        check_eq("stall_hold", int'(inst_address), 12);
        idle_step();
        check_eq("after_stall", int'(inst_address), 13);

        // Absolute and relative branches, including negative wrap
        step(1'b1, 3, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        step(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 100);
        check_eq("br_abs", int'(inst_address), 100);
        step(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 'h3FE);
        check_eq("br_rel_neg", int'(inst_address), 98);
        step(1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        step(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 'h3FD);
        check_eq("br_rel_wrap", int'(inst_address), 1022);
        check_eq("br_wrap_fault", int'(fault), 0);

        // Sequential run off the end of the ROM
        step(1'b1, 1020, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        for (int i = 0; i < 4; i++) idle_step();
        check_eq("end_fault", int'(fault), 1);
        check_eq("end_pc", int'(inst_address), 1023);

        // Start from DONE clears fault; restart mid-run
        step(1'b1, 30, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        for (int i = 0; i < 10; i++) idle_step();
        step(1'b1, 7, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        check_eq("restart_addr", int'(inst_address), 7);
        check_eq("restart_cnt",  int'(cycle_count),  0);
        step(1'b1, 7, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        step(1'b1, 7, 1'b0, 1'b0, 1'b0, 1'b0, 0);

        // Long run to saturate the counter
        for (int i = 0; i < CNT_MAX + 10; i++) idle_step();
        check_eq("count_sat", int'(cycle_count), CNT_MAX);

        // Reset mid-run, then stay idle without start
        async_reset();
        idle_step();
        idle_step();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                async_reset();
            end else begin
                step(($urandom_range(0, 99) < 4),
                     ($urandom_range(0, 3) == 0) ? int'($urandom_range(1000, 1023)) : int'($urandom_range(0, 1023)),
                     ($urandom_range(0, 99) < 15),
                     ($urandom_range(0, 99) < 3),
                     ($urandom_range(0, 99) < 10),
                     ($urandom_range(0, 1) == 1),
                     int'($urandom_range(0, 1023)));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/inst_fetch_ctrl.md
# inst_fetch_ctrl

Fetch sequencer for the 3BC processor's instruction memory. Holds the program counter and drives the 10-bit instruction address into the combinational instruction ROM. It runs the start/done handshake with the testbench and applies stall, halt, and branch decisions from the decode/datapath stage. It sits between the top-level control and the ROM and is the only driver of the ROM address.

## Interface
- AW, 10, instruction address width (ROM depth 2**AW)
- CW, 16, cycle counter width
- Clk  input  1  clock; all state updates on rising edge
- Reset  input  1  asynchronous active-low reset (0 = reset)
- Start  input  1  request to begin/restart a program
- StartAddr  input  AW  PC value loaded on accepted Start
- Stall  input  1  hold PC this cycle (datapath busy)
- Halt  input  1  current instruction is a halt (from decode)
- BranchEn  input  1  current instruction redirects fetch
- BranchRel  input  1  1 = Target is signed PC-relative offset, 0 = absolute address
- Target  input  AW  branch target or signed offset
- InstAddress  output  AW  address to instruction ROM (= PC register)
- InstValid  output  1  ROM output is a live instruction this cycle
- Done  output  1  program finished (halt or fault)
- Fault  output  1  sequential fetch ran past the last ROM word
- CycleCount  output  CW  cycles spent in RUN, saturating

## Operation
- States: IDLE, RUN, DONE. The encoding is free. Outputs are registered or decoded from the state only.
- Reset (asynchronous): state IDLE, PC=0, InstValid=0, Done=0, Fault=0, CycleCount=0.
- IDLE: Start=1 loads PC=StartAddr, clears CycleCount and Fault, and moves to RUN. Start=0 leaves everything held.
- RUN: InstValid=1. Priority at each edge, highest first:
  - Start=1: restart. PC=StartAddr, CycleCount=0, Fault=0, stay in RUN.
  - Stall=1: PC held. Halt and BranchEn are ignored. CycleCount increments.
  - Halt=1: go to DONE with PC held and Fault=0.
  - BranchEn=1, BranchRel=0: PC=Target.
  - BranchEn=1, BranchRel=1: PC=(PC + signed Target) mod 2**AW. Wrap is legal here and not a fault.
  - Otherwise PC=PC+1. If PC = 2**AW−1, instead go to DONE with Fault=1 and PC held at 2**AW−1.
- CycleCount increments on every RUN cycle, including stall cycles and the halt cycle. It saturates at 2**CW−1 and does not wrap. It is unchanged outside RUN except when cleared by a Start.
- DONE: Done=1, InstValid=0. PC, CycleCount and Fault are held. Start=1 behaves exactly as in IDLE and moves to RUN.
- Halt, BranchEn, BranchRel and Target are don't-care outside RUN.

## Timing
- InstAddress comes straight from the PC register. The ROM is combinational, so the instruction is valid in the same cycle as the address.
- Decode inputs (Halt, BranchEn, Target) are combinational from that instruction and are sampled at the next rising edge.
- Start is sampled at the edge. The first InstValid=1 cycle is the cycle after Start is sampled, with InstAddress=StartAddr.
- Branch latency: the redirected address appears one cycle after the edge that samples BranchEn. There are no delay slots and no wasted fetch.
- Halt latency: Done=1 and InstValid=0 in the cycle after the edge that samples Halt.
- Start held high for several cycles restarts on every edge. PC stays at StartAddr and CycleCount stays at 0 until Start drops.
- A Reset assertion mid-RUN forces the reset values immediately, without waiting for a clock edge. After release the block waits in IDLE for Start.

## Test plan
- Reset release, then Start=1 with StartAddr=0 for one cycle, no branches, Halt asserted when InstAddress=5 → InstAddress runs 0,1,2,3,4,5. Done=1 on the next cycle, PC stays at 5, CycleCount=6, Fault=0.
- From StartAddr=10, Stall=1 for 3 cycles at PC=12 → InstAddress holds 12 for 4 cycles total and then continues to 13. CycleCount includes the stall cycles.
- Absolute branch at PC=3 with Target=100 → next address is 100. Relative branch at PC=100 with Target=10'h3FE (−2) → next address is 98. Relative branch at PC=1 with Target=10'h3FD (−3) → next address is 1022 with Fault=0.
- StartAddr=1020 with no halt → addresses run 1020 through 1023. Done=1 and Fault=1 on the next cycle, PC held at 1023.
- Start pulsed while in RUN at PC=40 with StartAddr=7 → next address is 7 and CycleCount restarts from 0. Start pulsed in DONE → run resumes and both Done and Fault clear.
- Reset driven low mid-RUN between clock edges → InstAddress=0, InstValid=0, Done=0 and CycleCount=0 immediately, without waiting for an edge. The block stays in IDLE until the next Start.
